// File: rtl/fetch_unit.sv
// fetch_unit: IF stage; owns PC, drives imem (imemREN/imemaddr), feeds IF/ID (ifinstr, ifJALjump_addr, ifW, ifRST), absorbs stall/redirect/halt, counts accepted fetches
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifinstr,
  output logic [31:0] ifJALjump_addr,
  output logic        ifW,
  output logic        ifRST,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, next_state;
  logic [31:0] pc, pend_addr;
  logic pend, live, flush, adv;
  assign live = nRST & (state == RUN);
  assign flush = live & (halt | redirect_en | (pend & ihit));
  assign adv = live & ~halt & ~redirect_en & ~pend & ~stall & ihit;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= RUN;
    else state <= next_state;
  always_comb next_state = (live & halt) ? HALTED : state;
  always_comb begin
    imemREN = state == RUN;
    imemaddr = pc;
    ifinstr = imemload;
    ifJALjump_addr = pc + PC_STEP;
    ifW = flush | adv;
    ifRST = flush;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      pc <= PC_INIT;
      pend <= 1'b0;
      pend_addr <= 32'h0;
      fetch_count <= 32'h0;
    end else if (live & ~halt) begin
      if (redirect_en) begin
        pend <= ~ihit;
        if (ihit) pc <= redirect_addr;
        else pend_addr <= redirect_addr;
      end else if (pend) begin
        if (ihit) begin
          pc <= pend_addr;
          pend <= 1'b0;
        end
      end else if (adv) begin
        pc <= pc + PC_STEP;
        fetch_count <= fetch_count + 32'd1;
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic n_rst, ihit, stall, redirect_en, halt;
  logic [31:0] imemload, redirect_addr;
  logic imem_ren, if_w, if_rst;
  logic [31:0] imem_addr, if_instr, if_jal, fetch_count;
  typedef struct packed {
    logic [31:0] addr;
    logic ren, w, rst;
    logic [31:0] instr, jal, cnt;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .CLK(clk), .nRST(n_rst), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .halt(halt),
    .imemREN(imem_ren), .imemaddr(imem_addr), .ifinstr(if_instr),
    .ifJALjump_addr(if_jal), .ifW(if_w), .ifRST(if_rst), .fetch_count(fetch_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imemaddr", imem_addr, e.addr);
      chk("imemREN", 32'(imem_ren), 32'(e.ren));
      chk("ifW", 32'(if_w), 32'(e.w));
      chk("ifRST", 32'(if_rst), 32'(e.rst));
      chk("ifinstr", if_instr, e.instr);
      chk("ifJALjump_addr", if_jal, e.jal);
      chk("fetch_count", fetch_count, e.cnt);
    end
  task automatic cyc(input logic n, input logic ih, input logic st, input logic re,
                     input logic [31:0] ra, input logic ha, input logic [31:0] ea,
                     input logic er, input logic ew, input logic ers, input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    n_rst = n;
    ihit = ih;
    stall = st;
    redirect_en = re;
    redirect_addr = ra;
    halt = ha;
    imemload = {16'hC0DE, ea[15:0]} ^ 32'h0000_5A5A;
    e.addr = ea;
    e.ren = er;
    e.w = ew;
    e.rst = ers;
    e.instr = imemload;
    e.jal = ea + 32'd4;
    e.cnt = ec;
    q.push_back(e);
  endtask
  initial begin
    n_rst = 1'b0;
    ihit = 1'b1;
    stall = 1'b0;
    redirect_en = 1'b0;
    redirect_addr = 32'h0;
    halt = 1'b0;
    imemload = 32'h0;
    cyc(0,1,0,0,32'h0,0, 32'h00,1,0,0,0);
    cyc(1,1,0,0,32'h0,0, 32'h00,1,1,0,0);
    cyc(1,1,0,0,32'h0,0, 32'h04,1,1,0,1);
    cyc(1,1,0,0,32'h0,0, 32'h08,1,1,0,2);
    cyc(1,1,0,0,32'h0,0, 32'h0C,1,1,0,3);
    cyc(1,0,0,0,32'h0,0, 32'h10,1,0,0,4);
    cyc(1,0,0,0,32'h0,0, 32'h10,1,0,0,4);
    cyc(1,0,0,0,32'h0,0, 32'h10,1,0,0,4);
    cyc(1,1,0,0,32'h0,0, 32'h10,1,1,0,4);
    cyc(1,1,0,0,32'h0,0, 32'h14,1,1,0,5);
    cyc(1,1,0,0,32'h0,0, 32'h18,1,1,0,6);
    cyc(1,1,0,0,32'h0,0, 32'h1C,1,1,0,7);
    cyc(1,1,1,0,32'h0,0, 32'h20,1,0,0,8);
    cyc(1,1,1,0,32'h0,0, 32'h20,1,0,0,8);
    cyc(1,1,0,0,32'h0,0, 32'h20,1,1,0,8);
    cyc(1,1,0,0,32'h0,0, 32'h24,1,1,0,9);
    cyc(1,1,0,0,32'h0,0, 32'h28,1,1,0,10);
    cyc(1,1,0,0,32'h0,0, 32'h2C,1,1,0,11);
    cyc(1,0,0,1,32'h100,0, 32'h30,1,1,1,12);
    cyc(1,0,0,0,32'h0,0, 32'h30,1,0,0,12);
    cyc(1,1,0,0,32'h0,0, 32'h30,1,1,1,12);
    cyc(1,1,0,0,32'h0,0, 32'h100,1,1,0,12);
    cyc(1,1,1,1,32'h200,0, 32'h104,1,1,1,13);
    cyc(1,1,0,0,32'h0,0, 32'h200,1,1,0,13);
    cyc(1,0,0,1,32'h300,0, 32'h204,1,1,1,14);
    cyc(1,0,0,1,32'h40,0, 32'h204,1,1,1,14);
    cyc(1,0,1,0,32'h0,0, 32'h204,1,0,0,14);
    cyc(1,1,0,0,32'h0,0, 32'h204,1,1,1,14);
    cyc(1,1,0,1,32'h500,1, 32'h40,1,1,1,14);
    cyc(1,1,0,1,32'h500,0, 32'h40,0,0,0,14);
    cyc(1,1,0,0,32'h0,1, 32'h40,0,0,0,14);
    cyc(1,1,0,0,32'h0,0, 32'h40,0,0,0,14);
    cyc(0,1,0,0,32'h0,0, 32'h00,1,0,0,0);
    cyc(1,1,0,0,32'h0,0, 32'h00,1,1,0,0);
    cyc(1,1,0,0,32'h0,0, 32'h04,1,1,0,1);
    cyc(1,1,0,1,32'hFFFF_FFFC,0, 32'h08,1,1,1,2);
    cyc(1,1,0,0,32'h0,0, 32'hFFFF_FFFC,1,1,0,2);
    cyc(1,1,0,0,32'h0,0, 32'h00,1,1,0,3);
    cyc(1,0,0,1,32'h700,0, 32'h04,1,1,1,4);
    cyc(0,1,0,0,32'h0,0, 32'h00,1,0,0,0);
    cyc(1,1,0,0,32'h0,0, 32'h00,1,1,0,0);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
